mem_port_arbiter: RTL
=====================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DATA_FIRST, default 1, meaning data port wins simultaneous requests (0: instruction port wins).
REQ-002 SHALL have ports: clk  in  1  clock, rising edge; rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have instruction-side ports: inst_req in 1 fetch wanted; inst_addr in 32 fetch address; inst_rdata out 32 fetched word; stallreq_from_if out 1 fetch not complete.
REQ-004 SHALL have data-side ports: data_req in 1; data_wr in 1 (1=store); data_size in 2; data_wstrb in 4; data_addr in 32; data_wdata in 32; data_rdata out 32; stallreq_from_mem out 1 access not complete.
REQ-005 SHALL have pipeline ports: pipe_stall in 1 (1=pipeline held this cycle); flush_except in 1 exception flush.
REQ-006 SHALL have shared memory ports: mem_req out 1; mem_wr out 1; mem_size out 2; mem_wstrb out 4; mem_addr out 32; mem_wdata out 32; mem_addr_ok in 1; mem_data_ok in 1; mem_rdata in 32.

Function
REQ-007 SHALL implement FSM states IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
REQ-008 IDLE SHALL grant data when data_req & ~d_done, else inst when inst_req & ~i_done (order swapped if DATA_FIRST=0), going to D_ADDR/I_ADDR next cycle.
REQ-009 On grant, request fields SHALL be captured into holding registers; mem_wr/size/wstrb/addr/wdata SHALL be driven only from these registers (instruction grant: mem_wr=0, mem_size=2, mem_wstrb=0).
REQ-010 mem_req SHALL be 1 exactly in D_ADDR/I_ADDR; mem_req SHALL NOT drop before mem_addr_ok, and holding registers SHALL stay stable meanwhile.
REQ-011 X_ADDR with mem_addr_ok SHALL go to X_DATA; X_DATA with mem_data_ok SHALL go to IDLE; mem_data_ok outside X_DATA SHALL be ignored.
REQ-012 On mem_data_ok in D_DATA, data_rdata <= mem_rdata and d_done <= 1 (stores: set d_done, data_rdata unchanged); same for I_DATA with inst_rdata and i_done.
REQ-013 d_done and i_done SHALL clear on any edge with pipe_stall=0 or flush_except=1; a same-edge set (REQ-012) SHALL win over pipe_stall clear but lose to flush_except.
REQ-014 stallreq_from_mem = data_req & ~d_done; stallreq_from_if = (inst_req & ~i_done) | discard (combinational).
REQ-015 flush_except while in I_ADDR/I_DATA/D_ADDR/D_DATA SHALL set discard; the transaction SHALL complete its handshake but SHALL NOT update rdata or done; discard clears at that mem_data_ok.
REQ-016 Best-case latency: request seen in IDLE at cycle 0, addr_ok in cycle 1, data_ok in cycle 2 -> stall low from cycle 3.
REQ-017 After completion SHALL return to IDLE for one cycle before the next grant (no back-to-back issue).
REQ-018 Arbiter SHALL never have more than one outstanding memory transaction.

Reset
REQ-019 rst=0 SHALL asynchronously force IDLE, mem_req=0, all holding registers, inst_rdata, data_rdata, d_done, i_done, discard to 0; stall outputs then follow REQ-014.
REQ-020 Reset mid-transaction SHALL abandon it without waiting for memory handshakes.

Verification
REQ-021 Load: data_req=1, data_addr=0x1000, addr_ok/data_ok immediate, mem_rdata=0xDEADBEEF -> mem_req only in cycle 1, data_rdata=0xDEADBEEF and stallreq_from_mem=0 in cycle 3.
REQ-022 Simultaneous inst_req (0xBFC00000) and data_req (store 0x2000, wstrb=0xF), DATA_FIRST=1 -> store issued first, fetch mem_req no earlier than 2 cycles after store data_ok.
REQ-023 addr_ok delayed 4 cycles while data_addr changes -> mem_req held 4 cycles, mem_addr stays 0x1000.
REQ-024 flush_except during I_DATA, data_ok with 0x12345678 -> inst_rdata unchanged, i_done=0, stallreq_from_if=1 until data_ok.
REQ-025 Load done while pipe_stall=1 for 3 cycles -> d_done held, stallreq_from_mem=0, no reissue; cleared after pipe_stall=0.
REQ-026 rst=0 asserted in D_ADDR between clock edges -> mem_req=0 and state IDLE before next edge.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-outstanding memory port between instruction and data sides,
// with done flags that hold results across pipeline stalls and discard of flushed transactions.
module mem_port_arbiter #(
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        stallreq_from_if,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        stallreq_from_mem,
  input  logic        pipe_stall,
  input  logic        flush_except,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA} state_t;
  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [31:0] data_rdata_q, data_rdata_d, inst_rdata_q, inst_rdata_d;
  logic        d_done_q, d_done_d, i_done_q, i_done_d, discard_q, discard_d;
  logic        d_go, i_go, ld_d, ld_i, d_fin, i_fin, keep_d, keep_i, clr;
  assign d_go   = data_req & ~d_done_q;
  assign i_go   = inst_req & ~i_done_q;
  assign ld_d   = (state_q == IDLE) & d_go & (DATA_FIRST | ~i_go);
  assign ld_i   = (state_q == IDLE) & i_go & ~ld_d;
  assign d_fin  = (state_q == D_DATA) & mem_data_ok;
  assign i_fin  = (state_q == I_DATA) & mem_data_ok;
  // a flush on the completing edge discards the result just like an earlier flush
  assign keep_d = d_fin & ~discard_q & ~flush_except;
  assign keep_i = i_fin & ~discard_q & ~flush_except;
  assign clr    = flush_except | ~pipe_stall;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ld_d ? D_ADDR : ld_i ? I_ADDR : IDLE;
      D_ADDR:  state_d = mem_addr_ok ? D_DATA : D_ADDR;
      D_DATA:  state_d = mem_data_ok ? IDLE : D_DATA;
      I_ADDR:  state_d = mem_addr_ok ? I_DATA : I_ADDR;
      I_DATA:  state_d = mem_data_ok ? IDLE : I_DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_d         = ld_d ? data_wr : ld_i ? 1'b0 : wr_q;
    size_d       = ld_d ? data_size : ld_i ? 2'd2 : size_q;
    wstrb_d      = ld_d ? data_wstrb : ld_i ? 4'd0 : wstrb_q;
    addr_d       = ld_d ? data_addr : ld_i ? inst_addr : addr_q;
    wdata_d      = ld_d ? data_wdata : ld_i ? 32'd0 : wdata_q;
    d_done_d     = keep_d | (d_done_q & ~clr);
    i_done_d     = keep_i | (i_done_q & ~clr);
    data_rdata_d = (keep_d & ~wr_q) ? mem_rdata : data_rdata_q;
    inst_rdata_d = keep_i ? mem_rdata : inst_rdata_q;
    discard_d    = (d_fin | i_fin) ? 1'b0 : discard_q | ((state_q != IDLE) & flush_except);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      wr_q         <= 1'b0;
      size_q       <= 2'd0;
      wstrb_q      <= 4'd0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      data_rdata_q <= 32'd0;
      inst_rdata_q <= 32'd0;
      d_done_q     <= 1'b0;
      i_done_q     <= 1'b0;
      discard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_q         <= wr_d;
      size_q       <= size_d;
      wstrb_q      <= wstrb_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      data_rdata_q <= data_rdata_d;
      inst_rdata_q <= inst_rdata_d;
      d_done_q     <= d_done_d;
      i_done_q     <= i_done_d;
      discard_q    <= discard_d;
    end
  end
  assign mem_req           = (state_q == D_ADDR) | (state_q == I_ADDR);
  assign mem_wr            = wr_q;
  assign mem_size          = size_q;
  assign mem_wstrb         = wstrb_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = wdata_q;
  assign data_rdata        = data_rdata_q;
  assign inst_rdata        = inst_rdata_q;
  assign stallreq_from_mem = data_req & ~d_done_q;
  assign stallreq_from_if  = (inst_req & ~i_done_q) | discard_q;
endmodule
